// File: rtl/counter_seq_pkg.sv
// Shared constants for counter_sequencer: FSM state encoding and run-mode values.
package counter_seq_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_sequencer_tick_gen.sv
// Prescaler for counter_sequencer: one-clock tick every PRESCALE enabled clocks.
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt;

  // The tick lands on the last clock of each PRESCALE-clock window.
  assign tick = en && (cnt == CW'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Loadable down-counter sequencer: one-shot/auto-reload, pause/resume, abort, tc pulse.
// Define COUNTER_SEQUENCER_PRESCALE_EN to count once every PRESCALE clocks.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_reg;
  logic             mode_reg;
  logic             tick;
  logic             terminal;

`ifdef COUNTER_SEQUENCER_PRESCALE_EN
  logic presc_clr;

  // Any load, resume or abort restarts the prescaler window.
  assign presc_clr = abort || (start && (state != S_RUN));

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (clear),
    .clr  (presc_clr),
    .en   (state == S_RUN),
    .tick (tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tick = 1'b1;
`endif

  assign terminal = tick && (count == WIDTH'(1));
  assign busy     = (state == S_RUN) || (state == S_PAUSE);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state      <= S_IDLE;
      count      <= '0;
      tc         <= 1'b0;
      reload_reg <= '0;
      mode_reg   <= MODE_ONESHOT;
    end else begin
      tc <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        count <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start && (load_val != '0)) begin
              reload_reg <= load_val;
              mode_reg   <= mode;
              count      <= load_val;
              state      <= S_RUN;
            end
          end
          S_RUN: begin
            // start outranks pause; a one-shot terminal tick below overrides PAUSE with DONE.
            if (!start && pause) begin
              state <= S_PAUSE;
            end
            if (terminal) begin
              tc <= 1'b1;
              if (mode_reg == MODE_RELOAD) begin
                count <= reload_reg;
              end else begin
                count <= '0;
                state <= S_DONE;
              end
            end else if (tick) begin
              count <= count - 1'b1;
            end
          end
          S_PAUSE: begin
            if (start) begin
              state <= S_RUN;
            end
          end
          default: begin
            state <= S_IDLE;
            count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller that sequences a loadable down-counter: start, pause/resume, abort, one-shot or auto-reload.
- Produces a terminal-count pulse.
- Sits between control logic and the counter datapath; it owns the count register and the run state.
- Used as the timing/period source for downstream lab blocks (dividers, blinkers, sequencers).

Parameters:
- WIDTH, 8, width of the count and load value.
- PRESCALE, 4, clocks per count tick; used only when PRESCALE_EN is defined; legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear  input  1  asynchronous, active-high reset.
- start  input  1  level sampled each clock; in IDLE/DONE it loads and runs; in PAUSE it resumes.
- pause  input  1  in RUN, freezes the count.
- abort  input  1  returns to IDLE from any state.
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled with start from IDLE/DONE only.
- load_val  input  WIDTH  period N; sampled with start from IDLE/DONE only.
- count  output  WIDTH  current count value, registered.
- tc  output  1  terminal-count pulse, one clock wide, registered.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  high in DONE.

Behaviour:
- Reset (clear=1, asynchronous): state=IDLE, count=0, tc=0, busy=0, done=0, reload_reg=0, mode_reg=0, prescaler=0.
- States: IDLE, RUN, PAUSE, DONE.
- Per-cycle priority: abort > start > pause.
- tc is 0 in every cycle that is not a terminal tick.

IDLE:
- start=1 and load_val!=0: reload_reg<=load_val, mode_reg<=mode, count<=load_val, go to RUN.
- start=1 and load_val==0: ignored; stay in IDLE, count unchanged, no tc.

RUN:
- On each tick, if count>1: count<=count-1.
- On a tick with count==1 (terminal tick), tc<=1, then:
  - mode_reg=0: count<=0, go to DONE.
  - mode_reg=1: count<=reload_reg, stay in RUN.
- Period is exactly N ticks; first tc arrives N ticks after the cycle in which count first shows N.
- pause=1: go to PAUSE; count holds at the value reached this cycle.
- pause on a terminal tick: tc still fires and count updates.
  - One-shot: go to DONE (DONE wins over PAUSE).
  - Auto-reload: go to PAUSE holding reload_reg.

PAUSE:
- count holds, tc=0.
- start=1: go to RUN with no reload; load_val and mode are ignored.
- pause has no effect in PAUSE.

DONE:
- done=1, count=0.
- start=1: reload as from IDLE (same load_val==0 rule) and go to RUN.

Any state:
- abort=1: count<=0, tc<=0, go to IDLE; overrides a simultaneous terminal tick, so no tc.
- Changes on load_val/mode while in RUN or PAUSE have no effect until the next start from IDLE/DONE.
- busy and done are decoded from the registered state, so they change in the same cycle as the state.

Optional Feature:
- Macro: COUNTER_SEQUENCER_PRESCALE_EN.
- Defined:
  - A tick occurs once every PRESCALE clocks while in RUN.
  - The prescaler clears on every load, resume or abort and holds in PAUSE.
  - The first tick comes PRESCALE clocks after entry to RUN.
- Undefined:
  - Tick=1 on every clock in RUN; the PRESCALE parameter is ignored.

Decomposition:
- Shared package counter_seq_pkg:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_PAUSE=2'd2, S_DONE=2'd3.
  - MODE_ONESHOT=1'b0, MODE_RELOAD=1'b1.
- One sub-module: tick_gen, the prescaler producing a one-clock tick enable, with a clear input.
  - Instantiated only under the macro; otherwise tick is tied high.

Test Plan:
- Reset mid-RUN: assert clear while count=3 -> same cycle count=0, busy=0, tc=0; after release, stays in IDLE.
- One-shot, load_val=5, mode=0, one-clock start -> count shows 5,4,3,2,1,0 on successive clocks; tc=1 only on the cycle count=0; then done=1, busy=0.
- Auto-reload, load_val=3, mode=1 -> count sequence 3,2,1,3,2,1,...; tc pulses every 3 clocks; done stays 0; abort -> count=0, IDLE.
- Pause/resume, load_val=6 -> pause at count=4, holds 4 for 5 clocks with tc=0; start resumes 3,2,1,0; load_val changed to 9 during pause has no effect.
- Boundaries:
  - start with load_val=0 -> stays in IDLE, no tc.
  - abort and terminal tick in the same cycle -> no tc, IDLE.
  - pause on a one-shot terminal tick -> tc=1, DONE.
- With COUNTER_SEQUENCER_PRESCALE_EN and PRESCALE=4, load_val=2, one-shot -> count changes every 4 clocks; tc arrives 8 clocks after count first shows 2.
